// File: rtl/z80_bus_master_pkg.sv
// Shared types for the secondary Z80 bus initiator.
// Operation codes and FSM state encoding.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        OP_MEM_RD = 2'b00,
        OP_MEM_WR = 2'b01,
        OP_IO_RD  = 2'b10,
        OP_IO_WR  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        TW   = 3'd4,
        T3   = 3'd5,
        OWN  = 3'd6
    } state_e;

    function automatic logic op_is_io(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_wr(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/z80_bus_master_if.sv
// Command/response handshake plus Z80 bus pins of the initiator.
// master = the bus master itself, slave = host/bus side.
interface z80_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busreq_n;
    logic        busack_n;
    logic        bus_oe;
    logic        data_oe;
    logic [15:0] addr_o;
    logic [7:0]  data_o;
    logic [7:0]  data_i;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        wait_n;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  busack_n, data_i, wait_n,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output busreq_n, bus_oe, data_oe, addr_o, data_o,
        output mreq_n, iorq_n, rd_n, wr_n
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output busack_n, data_i, wait_n,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  busreq_n, bus_oe, data_oe, addr_o, data_o,
        input  mreq_n, iorq_n, rd_n, wr_n
    );
endinterface

// File: rtl/z80_bus_master.sv
// Z80 bus initiator: acquires the bus via BUSREQ/BUSACK and runs
// single memory/IO cycles with T-state timing, WAIT and timeout.
module z80_bus_master
    import z80_bus_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input logic             clk_i,
    input logic             rst_n_i,
    z80_bus_master_if.master bus
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_CYCLES);
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_TIMEOUT);

    state_e      st_q, st_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [7:0]  idle_q, idle_d;
    logic        err_q, err_d;
    logic        accept;

    logic        busreq_n_q, busreq_n_d;
    logic        bus_oe_q, bus_oe_d;
    logic        data_oe_q, data_oe_d;
    logic        mreq_n_q, mreq_n_d;
    logic        iorq_n_q, iorq_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        strobe, drive;

    assign accept = bus.cmd_valid & cmd_ready_q;

    always_comb begin
        st_d   = st_q;
        wcnt_d = wcnt_q;
        idle_d = idle_q;
        err_d  = err_q;
        unique case (st_q)
            IDLE: if (accept) st_d = REQ;
            REQ:  if (!bus.busack_n) st_d = T1;
            T1: begin
                st_d   = T2;
                wcnt_d = '0;
                err_d  = 1'b0;
            end
            T2: begin
                if (!bus.wait_n || op_is_io(op_q)) st_d = TW;
                else                               st_d = T3;
            end
            TW: begin
                wcnt_d = wcnt_q + 8'd1;
                if (bus.wait_n) begin
                    st_d = T3;
                end else if (wcnt_d == WAIT_LIM) begin
                    st_d  = T3;
                    err_d = 1'b1;
                end
            end
            T3: begin
                st_d   = OWN;
                idle_d = '0;
            end
            OWN: begin
                if (accept) begin
                    st_d   = T1;
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 8'd1;
                    if (idle_d == HOLD_LIM) st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each register
    // presents the levels of the state it is entering.
    always_comb begin
        op_d    = accept ? bus.cmd_op : op_q;
        addr_d  = accept ? bus.cmd_addr : addr_q;
        wdata_d = accept ? bus.cmd_wdata : wdata_q;
        drive   = st_d inside {T1, T2, TW, T3, OWN};
        strobe  = st_d inside {T2, TW, T3};

        busreq_n_d  = (st_d == IDLE);
        bus_oe_d    = drive;
        data_oe_d   = drive && (st_d != OWN) && op_is_wr(op_d);
        mreq_n_d    = !(strobe && !op_is_io(op_d));
        iorq_n_d    = !(strobe && op_is_io(op_d));
        rd_n_d      = !(strobe && !op_is_wr(op_d));
        wr_n_d      = !(strobe && op_is_wr(op_d));
        cmd_ready_d = (st_d == IDLE) || (st_d == OWN);
        rsp_valid_d = (st_q == T3);
        rsp_err_d   = (st_q == T3) && err_q;
        rdata_d     = rdata_q;
        if ((st_q == T3) && !op_is_wr(op_q)) rdata_d = bus.data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q        <= IDLE;
            op_q        <= '0;
            wcnt_q      <= '0;
            idle_q      <= '0;
            err_q       <= 1'b0;
            busreq_n_q  <= 1'b1;
            bus_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            mreq_n_q    <= 1'b1;
            iorq_n_q    <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            st_q        <= st_d;
            op_q        <= op_d;
            wcnt_q      <= wcnt_d;
            idle_q      <= idle_d;
            err_q       <= err_d;
            busreq_n_q  <= busreq_n_d;
            bus_oe_q    <= bus_oe_d;
            data_oe_q   <= data_oe_d;
            mreq_n_q    <= mreq_n_d;
            iorq_n_q    <= iorq_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.busreq_n  = busreq_n_q;
    assign bus.bus_oe    = bus_oe_q;
    assign bus.data_oe   = data_oe_q;
    assign bus.mreq_n    = mreq_n_q;
    assign bus.iorq_n    = iorq_n_q;
    assign bus.rd_n      = rd_n_q;
    assign bus.wr_n      = wr_n_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.addr_o    = addr_q;
    assign bus.data_o    = wdata_q;

endmodule
